// File: rtl/line_buffer_3row_if.sv
// Pixel-stream bus for line_buffer_3row: raster input side and three-row window output side.
interface line_buffer_3row_if #(
    parameter int WIDTH = 8
);
    logic             valid_in;
    logic             sof;
    logic [WIDTH-1:0] din;
    logic             valid_out;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;
    logic             frame_done;

    modport master (
        output valid_in, sof, din,
        input  valid_out, dout1, dout2, dout3, frame_done
    );

    modport slave (
        input  valid_in, sof, din,
        output valid_out, dout1, dout2, dout3, frame_done
    );
endinterface

// File: rtl/line_buffer_3row.sv
// Three-row line buffer feeding a 3x3 window stage; two line memories hold rows y-1 and y-2.
// Optional top-border replication enabled by defining BORDER_REPLICATE_EN.
module line_buffer_3row #(
    parameter logic [10:0] PIC_WIDTH  = 11'd250,
    parameter logic [10:0] PIC_HEIGHT = 11'd250,
    parameter int          WIDTH      = 8
) (
    input logic               clk,
    input logic               rst_n,
    line_buffer_3row_if.slave lb
);
    localparam int CW = (PIC_WIDTH  > 11'd1) ? $clog2(PIC_WIDTH)  : 1;
    localparam int RW = (PIC_HEIGHT > 11'd1) ? $clog2(PIC_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 11'd1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 11'd1);

    localparam logic [1:0] FILL0 = 2'd0;
    localparam logic [1:0] FILL1 = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    logic [WIDTH-1:0] line_a [0:PIC_WIDTH-1];
    logic [WIDTH-1:0] line_b [0:PIC_WIDTH-1];

    logic [CW-1:0]    col_q, col_d, addr;
    logic [RW-1:0]    row_q, row_d;
    logic [1:0]       state_q, state_d, cur_state;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic [WIDTH-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic             vld_q, vld_d, done_q, done_d;

    // sof forces the current pixel to row 0 / col 0 / FILL0 before anything else looks at it
    assign addr      = lb.sof ? '0 : col_q;
    assign cur_state = lb.sof ? FILL0 : state_q;
    assign rd_a      = line_a[addr];
    assign rd_b      = line_b[addr];

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        if (lb.valid_in) begin
            d3_d = lb.din;
            d2_d = rd_a;
            d1_d = rd_b;
`ifdef BORDER_REPLICATE_EN
            vld_d = 1'b1;
            if (cur_state == FILL0) begin
                d1_d = lb.din;
                d2_d = lb.din;
            end else if (cur_state == FILL1) begin
                d1_d = rd_a;
            end
`else
            vld_d = (cur_state == RUN);
`endif
            if (lb.sof) begin
                col_d   = CW'(1);
                row_d   = '0;
                state_d = FILL0;
            end else if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + RW'(1);
                end
                case (state_q)
                    FILL0:   state_d = FILL1;
                    FILL1:   state_d = RUN;
                    default: if (row_q == ROW_LAST) state_d = FILL0;
                endcase
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Read-before-write: lineB takes the row that lineA is about to lose
    always_ff @(posedge clk) begin
        if (lb.valid_in) begin
            line_a[addr] <= lb.din;
            line_b[addr] <= rd_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FILL0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    assign lb.valid_out  = vld_q;
    assign lb.dout1      = d1_q;
    assign lb.dout2      = d2_q;
    assign lb.dout3      = d3_q;
    assign lb.frame_done = done_q;
endmodule
